requant_pipe: RTL and testbench



---
 rtl/requant_pkg.sv | 26 ++
 rtl/requant_round_lane.sv | 50 +++++
 rtl/requant_pipe.sv | 171 +++++++++++++++++
 tb/tb_requant_pipe.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_pkg.sv
// -----------------------------------------------------------------------------
// requant_pkg
// Shared types and width helpers for the requantizer pipeline.
//   round_mode_e : per-beat rounding mode carried alongside each input beat
//   mid_width()  : width of the rounded intermediate, IN_W-SHIFT+1 bits, which
//                  holds floor(in / 2^SHIFT) plus a rounding increment without
//                  overflow
// -----------------------------------------------------------------------------
package requant_pkg;

    typedef enum logic [1:0] {
        RM_TRUNC     = 2'd0,
        RM_HALF_UP   = 2'd1,
        RM_HALF_EVEN = 2'd2,
        RM_HALF_AWAY = 2'd3
    } round_mode_e;

    function automatic int mid_width(input int in_w, input int shift);
        return in_w - shift + 1;
    endfunction

    localparam int DEF_IN_W  = 32;
    localparam int DEF_SHIFT = 9;
    localparam int DEF_MID_W = mid_width(DEF_IN_W, DEF_SHIFT);

endpackage

// File: rtl/requant_round_lane.sv
// -----------------------------------------------------------------------------
// requant_round_lane
// Combinational rounding of one signed lane: drops SHIFT fraction bits and
// applies the selected rounding increment.
//   din  : IN_W-bit signed input word
//   mode : rounding mode for this beat
//   r    : MID_W-bit signed rounded result (IN_W-SHIFT+1 bits)
// -----------------------------------------------------------------------------
module requant_round_lane
    import requant_pkg::*;
#(
    parameter  int IN_W  = 32,
    parameter  int SHIFT = 9,
    localparam int MID_W = mid_width(IN_W, SHIFT)
) (
    input  logic [IN_W-1:0]  din,
    input  round_mode_e      mode,
    output logic [MID_W-1:0] r
);

    // Bits strictly below the half bit; an all-zero mask when SHIFT is 1.
    localparam logic [IN_W-1:0] STICKY_MASK = (IN_W'(1) << (SHIFT - 1)) - IN_W'(1);

    logic [MID_W-1:0] q_s;
    logic             sign_s;
    logic             half_s;
    logic             sticky_s;
    logic             inc_s;

    // Floor quotient: arithmetic shift with one extra sign bit of headroom.
    assign sign_s   = din[IN_W-1];
    assign q_s      = {sign_s, din[IN_W-1:SHIFT]};
    assign half_s   = din[SHIFT-1];
    assign sticky_s = |(din & STICKY_MASK);

    // Rounding increment selection; ties are half set with sticky clear.
    always_comb begin
        inc_s = 1'b0;
        case (mode)
            RM_TRUNC:     inc_s = 1'b0;
            RM_HALF_UP:   inc_s = half_s;
            RM_HALF_EVEN: inc_s = half_s & (sticky_s | q_s[0]);
            RM_HALF_AWAY: inc_s = half_s & (sticky_s | ~sign_s);
            default:      inc_s = 1'b0;
        endcase
    end

    assign r = q_s + MID_W'(inc_s);

endmodule

// File: rtl/requant_pipe.sv
// -----------------------------------------------------------------------------
// requant_pipe
// Two-stage multi-lane requantizer: S1 rounds each lane, S2 saturates or wraps
// into OUT_W bits and registers the outputs. The whole pipe freezes while the
// output beat is held by downstream, so bubbles never compress under stall.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid/in_ready, in_data, in_mode, in_sat_en : input beat (mode and
//                  saturation enable travel with the beat)
//   out_valid/out_ready, out_data, out_sat : output beat and per-lane
//                  clipped/wrapped flags
//   sat_cnt      : saturating count of flagged lanes on output handshakes
//   sat_cnt_clr  : synchronous counter clear, wins over a same-cycle handshake
// -----------------------------------------------------------------------------
module requant_pipe
    import requant_pkg::*;
#(
    parameter int LANES = 4,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 9,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [1:0]             in_mode,
    input  logic                   in_sat_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    output logic [CNT_W-1:0]       sat_cnt,
    input  logic                   sat_cnt_clr
);

    localparam int MID_W = mid_width(IN_W, SHIFT);
    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam int EXT_W = MID_W - OUT_W + 1;

    localparam logic signed [MID_W-1:0] SAT_MAX = {{EXT_W{1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [MID_W-1:0] SAT_MIN = {{EXT_W{1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    logic                   advance_s;
    logic [MID_W-1:0]       rnd_s      [LANES];
    logic [MID_W-1:0]       s1_data_r  [LANES];
    logic                   s1_valid_r;
    logic                   s1_sat_en_r;
    logic [LANES*OUT_W-1:0] sat_data_s;
    logic [LANES-1:0]       sat_flag_s;
    logic [SUM_W-1:0]       cnt_sum_s;
    logic [CNT_W-1:0]       cnt_next_s;
    logic                   out_fire_s;

    // Single global enable: either the output slot is empty or it is leaving.
    assign advance_s  = !out_valid || out_ready;
    assign in_ready   = advance_s;
    assign out_fire_s = out_valid && out_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        requant_round_lane #(
            .IN_W  (IN_W),
            .SHIFT (SHIFT)
        ) u_round (
            .din  (in_data[k*IN_W +: IN_W]),
            .mode (round_mode_e'(in_mode)),
            .r    (rnd_s[k])
        );
    end

    // S1 register: rounded lanes plus the beat's saturation enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_sat_en_r <= 1'b0;
            s1_data_r   <= '{default: '0};
        end else if (advance_s) begin
            s1_valid_r  <= in_valid;
            s1_sat_en_r <= in_sat_en;
            s1_data_r   <= rnd_s;
        end else begin
            s1_valid_r  <= s1_valid_r;
            s1_sat_en_r <= s1_sat_en_r;
            s1_data_r   <= s1_data_r;
        end
    end

    // Range check per lane; the flag reports clipping or, with saturation off,
    // a wrap, while the data either clamps or keeps the low OUT_W bits.
    always_comb begin
        sat_data_s = '0;
        sat_flag_s = '0;
        for (int k = 0; k < LANES; k++) begin
            if ($signed(s1_data_r[k]) > SAT_MAX) begin
                sat_flag_s[k] = 1'b1;
                if (s1_sat_en_r) begin
                    sat_data_s[k*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
                end else begin
                    sat_data_s[k*OUT_W +: OUT_W] = s1_data_r[k][OUT_W-1:0];
                end
            end else if ($signed(s1_data_r[k]) < SAT_MIN) begin
                sat_flag_s[k] = 1'b1;
                if (s1_sat_en_r) begin
                    sat_data_s[k*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
                end else begin
                    sat_data_s[k*OUT_W +: OUT_W] = s1_data_r[k][OUT_W-1:0];
                end
            end else begin
                sat_data_s[k*OUT_W +: OUT_W] = s1_data_r[k][OUT_W-1:0];
            end
        end
    end

    // S2 output register; held stable while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (advance_s) begin
            out_valid <= s1_valid_r;
            out_data  <= sat_data_s;
            out_sat   <= sat_flag_s;
        end else begin
            out_valid <= out_valid;
            out_data  <= out_data;
            out_sat   <= out_sat;
        end
    end

    // Widened sum lets the clamp test see overflow past CNT_W bits.
    assign cnt_sum_s = SUM_W'(sat_cnt) + SUM_W'(popcount(out_sat));

    // Counter next state: clear beats a same-cycle handshake, then clamp.
    always_comb begin
        cnt_next_s = sat_cnt;
        if (sat_cnt_clr) begin
            cnt_next_s = '0;
        end else if (out_fire_s) begin
            if (cnt_sum_s > SUM_W'(CNT_MAX)) begin
                cnt_next_s = CNT_MAX;
            end else begin
                cnt_next_s = cnt_sum_s[CNT_W-1:0];
            end
        end else begin
            cnt_next_s = sat_cnt;
        end
    end

    // Saturation event counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= '0;
        end else begin
            sat_cnt <= cnt_next_s;
        end
    end

endmodule

// File: tb/tb_requant_pipe.sv
// -----------------------------------------------------------------------------
// tb_requant_pipe
// Self-checking bench for requant_pipe. Two instances share all stimulus: one
// with the default 16-bit counter and one with a 4-bit counter to reach the
// clamp. Expected beats come from an arithmetic rounding model.
// -----------------------------------------------------------------------------
module tb_requant_pipe;

    localparam int LANES = 4;
    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT = 9;

    typedef struct packed {
        logic [LANES*OUT_W-1:0] data;
        logic [LANES-1:0]       sat;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic [LANES*IN_W-1:0]  in_data;
    logic [1:0]             in_mode;
    logic                   in_sat_en;
    logic                   out_ready;
    logic                   sat_cnt_clr;
    logic                   in_ready;
    logic                   out_valid;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       out_sat;
    logic [15:0]            sat_cnt;
    logic                   in_ready4;
    logic                   out_valid4;
    logic [LANES*OUT_W-1:0] out_data4;
    logic [LANES-1:0]       out_sat4;
    logic [3:0]             sat_cnt4;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    cnt16_m = 0;
    int    cnt4_m  = 0;
    logic  last_in_fire = 1'b0;

    requant_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_sat_en(in_sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .sat_cnt(sat_cnt), .sat_cnt_clr(sat_cnt_clr)
    );

    requant_pipe #(.CNT_W(4)) u_dut_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_mode(in_mode), .in_sat_en(in_sat_en),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_sat(out_sat4), .sat_cnt(sat_cnt4), .sat_cnt_clr(sat_cnt_clr)
    );

    always #5 clk = ~clk;

    // Reference: exact value x / 2^SHIFT rounded by rule, then range-checked.
    function automatic beat_t model(input logic [LANES*IN_W-1:0] d, input logic [1:0] mode,
                                    input logic sat_en);
        beat_t       b;
        longint      x, q, rem, r;
        longint      unit = longint'(1) << SHIFT;
        longint      half = longint'(1) << (SHIFT - 1);
        longint      maxv = (longint'(1) << (OUT_W - 1)) - 1;
        longint      minv = -(longint'(1) << (OUT_W - 1));
        logic [63:0] rb;
        b = '0;
        for (int k = 0; k < LANES; k++) begin
            x   = longint'($signed(d[k*IN_W +: IN_W]));
            q   = x >>> SHIFT;
            rem = x - q * unit;
            case (mode)
                2'd1:    r = (rem >= half) ? q + 1 : q;
                2'd2:    r = (rem > half) ? q + 1 : ((rem == half) ? q + (q & 1) : q);
                2'd3:    r = (x >= 0) ? ((rem >= half) ? q + 1 : q) : ((rem > half) ? q + 1 : q);
                default: r = q;
            endcase
            rb = r;
            if (r > maxv || r < minv) begin
                b.sat[k] = 1'b1;
                if (sat_en) rb = (r > maxv) ? maxv : minv;
            end
            b.data[k*OUT_W +: OUT_W] = rb[OUT_W-1:0];
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w = w;
            1: w = 32'($signed(w) >>> $urandom_range(8, 22));
            2: begin w = 32'($signed(w) >>> 12); w[8:0] = 9'h100; end
            default: w[8:0] = 9'h100;
        endcase
        return w;
    endfunction

    function automatic logic [LANES*IN_W-1:0] rand_beat();
        logic [LANES*IN_W-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = rand_word();
        return d;
    endfunction

    // One clock: record handshakes into the model queues, then advance.
    task automatic tick();
        logic fire_out;
        int   pc;
        #1;
        last_in_fire = in_valid && in_ready && !rst;
        fire_out     = out_valid && out_ready && !rst;
        if (last_in_fire) exp_q.push_back(model(in_data, in_mode, in_sat_en));
        if (rst) begin
            while (exp_q.size() > obs_q.size()) exp_q.delete(exp_q.size() - 1);
            cnt16_m = 0;
            cnt4_m  = 0;
        end else begin
            if (fire_out) obs_q.push_back({out_data, out_sat});
            if (sat_cnt_clr) begin
                cnt16_m = 0;
                cnt4_m  = 0;
            end else if (fire_out && obs_q.size() <= exp_q.size()) begin
                pc      = $countones(exp_q[obs_q.size() - 1].sat);
                cnt16_m = (cnt16_m + pc > 65535) ? 65535 : cnt16_m + pc;
                cnt4_m  = (cnt4_m + pc > 15) ? 15 : cnt4_m + pc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output bit ok);
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        sat_cnt_clr = 1'b0;
        ok          = 1'b1;
        for (int i = 0; i < 30 && obs_q.size() < exp_q.size(); i++) tick();
        if (obs_q.size() != exp_q.size()) ok = 1'b0;
        tick();
        tick();
        if (obs_q.size() != exp_q.size()) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; in_sat_en = 1'b0;
        out_ready = 1'b1; sat_cnt_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== '0 || sat_cnt !== 16'h0 ||
            sat_cnt4 !== 4'h0 || in_ready !== 1'b1)
            $display("FAIL reset: got v=%b d=%h s=%b c=%h c4=%h rdy=%b required all zero, rdy=1",
                     out_valid, out_data, out_sat, sat_cnt, sat_cnt4, in_ready);
        if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== '0 || sat_cnt !== 16'h0 ||
            sat_cnt4 !== 4'h0 || in_ready !== 1'b1) errors++;
    endtask

    task automatic test_round_modes();
        logic [31:0] rv [14] = '{32'h00000300, 32'h00000300, 32'h00000300, 32'h00000300,
                                 32'h00000500, 32'h00000500, 32'h00000500, 32'h00000500,
                                 32'hFFFFFB00, 32'hFFFFFB00, 32'hFFFFFB00, 32'hFFFFFB00,
                                 32'hFFFFFB01, 32'hFFFFFB01};
        logic [1:0]  rm [14] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                                 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3};
        // -1279/512 is about -2.498, so both half-up and half-away give -2.
        logic [15:0] re [14] = '{16'h0001, 16'h0002, 16'h0002, 16'h0002,
                                 16'h0002, 16'h0003, 16'h0002, 16'h0003,
                                 16'hFFFD, 16'hFFFE, 16'hFFFE, 16'hFFFD,
                                 16'hFFFE, 16'hFFFE};
        int base = obs_q.size();
        bit ok;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1; in_data = rand_beat(); in_data[31:0] = rv[i];
            in_mode = rm[i]; in_sat_en = 1'($urandom_range(0, 1)); out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL round_latency_early[%0d]: got out_valid=%b required 0", i, out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data[15:0] !== re[i]) begin
                errors++;
                $display("FAIL round_lane0[%0d]: got v=%b %h required v=1 %h", i, out_valid,
                         out_data[15:0], re[i]);
            end
            tick();
        end
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL round_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = base; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL round_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [31:0] sv [4] = '{32'h01000000, 32'hFE000000, 32'hFF000000, 32'h01000000};
        logic        se [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] sd [4] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h8000};
        logic        ss [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int base = obs_q.size();
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = {LANES{sv[i]}}; in_mode = 2'd0; in_sat_en = se[i];
            tick();
        end
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sat_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < 4 && base + i < obs_q.size() && base + i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[base+i].data[15:0] !== sd[i] || obs_q[base+i].sat[0] !== ss[i] ||
                obs_q[base+i] !== exp_q[base+i]) begin
                errors++;
                $display("FAIL sat[%0d]: got %h sat=%b (beat %h) required %h sat=%b (beat %h)", i,
                         obs_q[base+i].data[15:0], obs_q[base+i].sat[0], obs_q[base+i],
                         sd[i], ss[i], exp_q[base+i]);
            end
        end
    endtask

    task automatic test_random(input int nbeats);
        int base = obs_q.size();
        int sent = 0;
        bit ok;
        in_valid = 1'b0;
        for (int c = 0; c < 4000 && sent < nbeats; c++) begin
            if (!in_valid || last_in_fire) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = rand_beat();
                in_mode   = 2'($urandom_range(0, 3));
                in_sat_en = 1'($urandom_range(0, 1));
            end
            out_ready   = ($urandom_range(0, 9) < 7);
            sat_cnt_clr = ($urandom_range(0, 19) == 0);
            tick();
            if (last_in_fire) sent++;
            checks++;
            if (sat_cnt !== 16'(cnt16_m) || sat_cnt4 !== 4'(cnt4_m)) begin
                errors++;
                $display("FAIL rand_cnt: got %0d/%0d required %0d/%0d", sat_cnt, sat_cnt4, cnt16_m, cnt4_m);
            end
        end
        drain(ok);
        checks++;
        if (!ok || sent != nbeats) begin
            errors++;
            $display("FAIL rand_count: got %0d out %0d sent required %0d %0d", obs_q.size(), sent,
                     exp_q.size(), nbeats);
        end
        for (int i = base; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [LANES*IN_W-1:0]  bp [8];
        logic [1:0]             bm [8];
        logic                   bs [8];
        logic [LANES*OUT_W-1:0] held = '0;
        int base = obs_q.size();
        int n = 0;
        bit ok;
        for (int i = 0; i < 8; i++) begin
            bp[i] = rand_beat(); bm[i] = 2'($urandom_range(0, 3)); bs[i] = 1'($urandom_range(0, 1));
        end
        sat_cnt_clr = 1'b0;
        for (int c = 0; c < 40 && (n < 8 || obs_q.size() < exp_q.size()); c++) begin
            out_ready = !(c >= 4 && c < 9);
            in_valid  = (n < 8);
            if (n < 8) begin in_data = bp[n]; in_mode = bm[n]; in_sat_en = bs[n]; end
            #1;
            if (c >= 4 && c < 9) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready[%0d]: got %b required 0", c, in_ready);
                end
                if (c == 4) held = out_data;
                else begin
                    checks++;
                    if (out_data !== held) begin
                        errors++;
                        $display("FAIL stall_hold[%0d]: got %h required %h", c, out_data, held);
                    end
                end
                checks++;
                if (sat_cnt !== 16'(cnt16_m)) begin
                    errors++;
                    $display("FAIL stall_cnt[%0d]: got %0d required %0d", c, sat_cnt, cnt16_m);
                end
            end
            tick();
            if (last_in_fire) n++;
        end
        drain(ok);
        checks++;
        if (!ok || n != 8 || obs_q.size() - base != 8) begin
            errors++;
            $display("FAIL stall_count: got %0d beats (%0d sent) required 8", obs_q.size() - base, n);
        end
        for (int i = base; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (sat_cnt !== 16'(cnt16_m) || sat_cnt4 !== 4'(cnt4_m)) begin
            errors++;
            $display("FAIL stall_cnt_end: got %0d/%0d required %0d/%0d", sat_cnt, sat_cnt4, cnt16_m, cnt4_m);
        end
    endtask

    task automatic test_counter();
        bit ok;
        in_valid = 1'b0; out_ready = 1'b1; sat_cnt_clr = 1'b1;
        tick();
        sat_cnt_clr = 1'b0;
        checks++;
        if (sat_cnt !== 16'h0 || sat_cnt4 !== 4'h0) begin
            errors++;
            $display("FAIL cnt_clear: got %0d/%0d required 0/0", sat_cnt, sat_cnt4);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = {LANES{32'h01000000}}; in_mode = 2'($urandom_range(0, 3));
            in_sat_en = 1'b1;
            tick();
        end
        drain(ok);
        checks++;
        if (!ok || sat_cnt !== 16'd20 || sat_cnt4 !== 4'd15) begin
            errors++;
            $display("FAIL cnt_clamp: got %0d/%0d required 20/15", sat_cnt, sat_cnt4);
        end
        in_valid = 1'b1; in_data = {LANES{32'hFE000000}}; in_sat_en = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        sat_cnt_clr = 1'b1;
        tick();
        sat_cnt_clr = 1'b0;
        checks++;
        if (sat_cnt !== 16'h0 || sat_cnt4 !== 4'h0 || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL cnt_clr_wins: got %0d/%0d (%0d of %0d beats) required 0/0",
                     sat_cnt, sat_cnt4, obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_inflight();
        int base;
        int seen = 0;
        bit ok;
        in_valid = 1'b1; in_data = {LANES{32'h01000000}}; in_sat_en = 1'b1; out_ready = 1'b1;
        tick();
        drain(ok);
        base = obs_q.size();
        in_valid = 1'b1; in_data = {LANES{32'h01000000}};
        tick();
        in_data = {LANES{32'hFE000000}};
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sat_cnt !== 16'h0 || sat_cnt4 !== 4'h0) begin
            errors++;
            $display("FAIL rst_inflight: got v=%b cnt=%0d/%0d required 0 0/0", out_valid, sat_cnt, sat_cnt4);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || obs_q.size() != base || !ok) begin
            errors++;
            $display("FAIL rst_discard: got %0d ghost cycles, %0d beats required 0, %0d", seen,
                     obs_q.size(), base);
        end
    endtask

    initial begin
        test_reset();
        test_round_modes();
        test_saturate();
        test_random(150);
        test_back_to_back_stall();
        test_counter();
        test_reset_inflight();
        test_random(60);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
